// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision sequential adder.
//   - state_t and state constants for the control FSM
//   - default chunk width and chunk count
//   - idx_width(): width of the chunk index counter
package mp_add_pkg;

    localparam int unsigned DefaultSize  = 16;
    localparam int unsigned DefaultWords = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StDone = 2'd2;

    // At least one bit, so that a degenerate WORDS still gives a legal vector.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_bpa.sv
// SIZE-bit binary parallel adder (BPA).
//   rst       in   active-low clear; forces sum/carry_out to 0 when low
//   a, b      in   SIZE-bit addends
//   carry_in  in   carry into bit 0
//   sum       out  SIZE-bit sum
//   carry_out out  carry out of bit SIZE-1
module mp_add_seq_bpa #(
    parameter int unsigned SIZE = 16
) (
    input  logic            rst,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            carry_in,
    output logic [SIZE-1:0] sum,
    output logic            carry_out
);

    logic [SIZE:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, carry_in};
        if (!rst) begin
            full = '0;
        end
        sum       = full[SIZE-1:0];
        carry_out = full[SIZE];
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision sequential adder. Adds two WORDS*SIZE-bit operands one SIZE-bit
// chunk per clock through a single BPA, least significant chunk first, chaining
// the carry between chunks.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept operands (IDLE and out of reset)
//   a_in, b_in in   WORDS*SIZE-bit operands
//   cin_in     in   carry into chunk 0
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   sum_out    out  WORDS*SIZE-bit sum (registered)
//   cout_out   out  carry out of the top chunk (registered)
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned SIZE  = DefaultSize,
    parameter int unsigned WORDS = DefaultWords
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*WORDS-1:0] a_in,
    input  logic [SIZE*WORDS-1:0] b_in,
    input  logic                  cin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE*WORDS-1:0] sum_out,
    output logic                  cout_out
);

    localparam int unsigned W    = SIZE * WORDS;
    localparam int unsigned IdxW = idx_width(WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic [IdxW-1:0] idx_q, idx_d;

    logic [SIZE-1:0] bpa_sum;
    logic            bpa_cout;

    mp_add_seq_bpa #(
        .SIZE (SIZE)
    ) u_bpa (
        .rst       (1'b1),
        .a         (a_q[SIZE-1:0]),
        .b         (b_q[SIZE-1:0]),
        .carry_in  (carry_q),
        .sum       (bpa_sum),
        .carry_out (bpa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin_in;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Each chunk sum enters at the top; after WORDS shifts chunk 0
                // has reached the bottom of res_q.
                res_d   = {bpa_sum, res_q[W-1:SIZE]};
                a_d     = a_q >> SIZE;
                b_d     = b_q >> SIZE;
                carry_d = bpa_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // State resets to IDLE, so in_ready is additionally held low during reset.
    assign in_ready  = rst && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum_out   = res_q;
    assign cout_out  = carry_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (SIZE=16, WORDS=4) against a plain
// arithmetic reference: {cout, sum} = a + b + cin at 65 bits.
module tb_mp_add_seq;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = SIZE * WORDS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;

    int checks = 0;
    int errors = 0;

    mp_add_seq #(
        .SIZE  (SIZE),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout_out  (cout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
        return r;
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for the accept edge, drop in_valid. Returns with
    // time just after the accept edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int guard;
        a_in     = a;
        b_in     = b;
        cin_in   = cin;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles after the accept edge until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_out_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;
        step();
        step();
        checks += 4;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
        end
        if (sum_out !== '0) begin
            errors++; $display("FAIL reset_sum: got %h required 0", sum_out);
        end
        if (cout_out !== 1'b0) begin
            errors++; $display("FAIL reset_cout: got %0b required 0", cout_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %0b required 1", in_ready);
        end
        step();
    endtask

    task automatic test_carry_chain();
        logic [W:0] exp;
        int lat;
        exp = ref_add(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        out_ready = 1'b0;
        accept(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        wait_out(lat);
        checks += 3;
        if (lat != WORDS) begin
            errors++; $display("FAIL carry_latency: got %0d required %0d", lat, WORDS);
        end
        if (sum_out !== exp[W-1:0]) begin
            errors++; $display("FAIL carry_sum: got %h required %h", sum_out, exp[W-1:0]);
        end
        if (cout_out !== exp[W]) begin
            errors++; $display("FAIL carry_cout: got %0b required %0b", cout_out, exp[W]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_full_ripple();
        logic [W:0] exp;
        int lat;
        exp = ref_add({W{1'b1}}, '0, 1'b1);
        accept({W{1'b1}}, '0, 1'b1);
        wait_out(lat);
        checks += 2;
        if (sum_out !== exp[W-1:0]) begin
            errors++; $display("FAIL ripple_sum: got %h required %h", sum_out, exp[W-1:0]);
        end
        if (cout_out !== exp[W]) begin
            errors++; $display("FAIL ripple_cout: got %0b required %0b", cout_out, exp[W]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W:0] exp;
        int lat;
        exp = ref_add(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        out_ready = 1'b0;
        accept(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 3; i++) begin
            // Stray operands during the stall must not be taken.
            in_valid = (i == 1);
            a_in     = rand64();
            b_in     = rand64();
            step();
            checks += 4;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_valid[%0d]: got %0b required 1", i, out_valid);
            end
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_ready[%0d]: got %0b required 0", i, in_ready);
            end
            if (sum_out !== exp[W-1:0]) begin
                errors++;
                $display("FAIL stall_sum[%0d]: got %h required %h", i, sum_out, exp[W-1:0]);
            end
            if (cout_out !== exp[W]) begin
                errors++;
                $display("FAIL stall_cout[%0d]: got %0b required %0b", i, cout_out, exp[W]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL post_stall_ready[%0d]: got %0b required 1", i, in_ready);
            end
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL post_stall_valid[%0d]: got %0b required 0", i, out_valid);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        logic [W:0] exp;
        int lat;
        logic seen;
        out_ready = 1'b1;
        accept(rand64(), rand64(), 1'b1);
        step();
        rst = 1'b0;
        #1;
        checks += 3;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ready: got %0b required 0", in_ready);
        end
        if (sum_out !== '0) begin
            errors++; $display("FAIL midrst_sum: got %h required 0", sum_out);
        end
        if (cout_out !== 1'b0) begin
            errors++; $display("FAIL midrst_cout: got %0b required 0", cout_out);
        end
        step();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL midrst_no_output: out_valid seen=%0b required 0", seen);
        end
        exp = ref_add(64'd5, 64'd7, 1'b0);
        out_ready = 1'b0;
        accept(64'd5, 64'd7, 1'b0);
        wait_out(lat);
        checks += 2;
        if (sum_out !== exp[W-1:0]) begin
            errors++; $display("FAIL midrst_next_sum: got %h required %h", sum_out, exp[W-1:0]);
        end
        if (cout_out !== exp[W]) begin
            errors++; $display("FAIL midrst_next_cout: got %0b required %0b", cout_out, exp[W]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random_ops();
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   exp;
        int           lat;
        int           stall;
        for (int n = 0; n < 12; n++) begin
            a = rand64();
            b = rand64();
            c = 1'($urandom_range(0, 1));
            if (n == 0) b = ~a;  // all-ones sum path
            exp = ref_add(a, b, c);
            out_ready = 1'b0;
            accept(a, b, c);
            wait_out(lat);
            stall = $urandom_range(0, 3);
            for (int i = 0; i < stall; i++) step();
            checks += 2;
            if (sum_out !== exp[W-1:0]) begin
                errors++; $display("FAIL rand_sum[%0d]: got %h required %h", n, sum_out, exp[W-1:0]);
            end
            if (cout_out !== exp[W]) begin
                errors++; $display("FAIL rand_cout[%0d]: got %0b required %0b", n, cout_out, exp[W]);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] expq[$];
        logic [W:0] exp;
        int cyc;
        int last_acc;
        int n_acc;
        int n_res;
        logic took;
        a_in      = rand64();
        b_in      = rand64();
        cin_in    = 1'($urandom_range(0, 1));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc      = 0;
        last_acc = -1;
        n_acc    = 0;
        n_res    = 0;
        while (n_res < 6 && cyc < 80) begin
            @(negedge clk);
            took = 1'b0;
            if (in_valid && in_ready) begin
                expq.push_back(ref_add(a_in, b_in, cin_in));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != WORDS + 2) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d required %0d",
                                 cyc - last_acc, WORDS + 2);
                    end
                end
                last_acc = cyc;
                n_acc++;
                took = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious: result with no pending op");
                end else begin
                    exp = expq.pop_front();
                    if ({cout_out, sum_out} !== exp) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %h required %h",
                                 n_res, {cout_out, sum_out}, exp);
                    end
                end
                n_res++;
            end
            @(posedge clk);
            #1;
            if (took) begin
                a_in   = rand64();
                b_in   = rand64();
                cin_in = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        checks++;
        if (n_res < 6) begin
            errors++; $display("FAIL b2b_timeout: results %0d required 6", n_res);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_full_ripple();
        test_backpressure();
        test_mid_reset();
        test_random_ops();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
